// File: rtl/bw_logic_unit.sv
// Bitwise AND/OR/XOR/NOR of two operands, SLICE bits per cycle; result valid WIDTH/SLICE cycles after accept.
// Backpressure: a result is held in DONE until out_ready; a new request can be taken on the same retiring edge.
module bw_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             result_zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] full_res;
  logic [WIDTH-1:0] slice_mask;
  logic             accept;

  always_comb begin
    case (op_q)
      2'b00:   full_res = a_q & b_q;
      2'b01:   full_res = a_q | b_q;
      2'b10:   full_res = a_q ^ b_q;
      default: full_res = ~(a_q | b_q);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    slice_mask = SLICE_MASK << (32'(cnt_q) * SLICE);

    case (state_q)
      IDLE: in_ready = 1'b1;
      BUSY: begin
        result_d = (result_q & ~slice_mask) | (full_res & slice_mask);
        // counter parks on the last slice so it never wraps inside BUSY
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + CW'(1);
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    accept = in_valid & in_ready;
    if (accept) begin
      state_d  = BUSY;
      cnt_d    = '0;
      result_d = '0;
      op_d     = op;
      a_d      = data_operandA;
      b_d      = data_operandB;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign data_result = result_q;
  assign result_zero = (result_q == '0);

endmodule

// File: tb/tb_bw_logic_unit.sv
// Scoreboard bench for bw_logic_unit: SLICE=8 main instance plus SLICE=32 and SLICE=4 instances on shared inputs.
module tb_bw_logic_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid, result_zero;
  logic [31:0] data_result;
  logic        in_ready_32, out_valid_32, result_zero_32;
  logic [31:0] data_result_32;
  logic        in_ready_4, out_valid_4, result_zero_4;
  logic [31:0] data_result_4;

  bw_logic_unit #(.WIDTH(32), .SLICE(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .data_operandA(a), .data_operandB(b), .out_valid(out_valid), .out_ready(out_ready),
    .data_result(data_result), .result_zero(result_zero));

  bw_logic_unit #(.WIDTH(32), .SLICE(32)) dut_32 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_32), .op(op),
    .data_operandA(a), .data_operandB(b), .out_valid(out_valid_32), .out_ready(out_ready),
    .data_result(data_result_32), .result_zero(result_zero_32));

  bw_logic_unit #(.WIDTH(32), .SLICE(4)) dut_4 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_4), .op(op),
    .data_operandA(a), .data_operandB(b), .out_valid(out_valid_4), .out_ready(out_ready),
    .data_result(data_result_4), .result_zero(result_zero_4));

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          acc;
  } exp_t;
  exp_t sb[$];
  logic ov_prev = 1'b0;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; all sampling happens on the falling edge.
  task automatic drive(input int v, input int o, input logic [31:0] x, input logic [31:0] y,
                       input int ordy, input int rst = 0);
    @(posedge clock);
    #1;
    reset     = 1'(rst);
    in_valid  = 1'(v);
    op        = 2'(o);
    a         = x;
    b         = y;
    out_ready = 1'(ordy);
    @(negedge clock);
    if (v != 0 && in_ready && rst == 0)
      sb.push_back('{res: model(2'(o), x, y), acc: cyc + 1});
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !out_valid; i++) drive(0, 0, '0, '0, 0);
    chk("wait_valid", 32'(out_valid), 32'd1);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
        else                chk("latency", 32'(cyc - sb[0].acc), 32'd4);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        chk("result", data_result, sb[0].res);
        chk("result_zero", 32'(result_zero), 32'(sb[0].res == '0));
        void'(sb.pop_front());
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    logic [31:0] held, x, y, exp35;
    int acc, l32, l8, l4;

    drive(0, 0, '0, '0, 0, 1);
    drive(0, 0, '0, '0, 0, 1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", data_result, 32'h0);

    drive(1, 0, 32'hF0F0_FFFF, 32'h0FF0_00FF, 1);
    repeat (6) drive(0, 0, '0, '0, 1);
    drive(1, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
    repeat (6) drive(0, 0, '0, '0, 1);
    drive(1, 3, 32'h0, 32'h0, 1);
    repeat (6) drive(0, 0, '0, '0, 1);

    // backpressure: result must stay frozen while inputs churn
    drive(1, 1, 32'h1234_5678, 32'h0F0F_0000, 0);
    wait_valid();
    held = model(2'b01, 32'h1234_5678, 32'h0F0F_0000);
    repeat (10) begin
      drive(1, $urandom_range(0, 3), $urandom, $urandom, 0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold", data_result, held);
    end
    drive(0, 0, '0, '0, 1);
    drive(0, 0, '0, '0, 1);
    chk("release_idle_valid", 32'(out_valid), 32'd0);
    chk("release_idle_ready", 32'(in_ready), 32'd1);

    // back-to-back: retire and accept on the same edge
    drive(1, 0, 32'hFFFF_0000, 32'hFF00_FF00, 0);
    wait_valid();
    drive(1, 1, 32'h1, 32'h2, 1);
    drive(0, 0, '0, '0, 1);
    chk("b2b_busy_valid", 32'(out_valid), 32'd0);
    chk("b2b_no_idle", 32'(in_ready), 32'd0);
    repeat (6) drive(0, 0, '0, '0, 1);

    // reset lands in the second BUSY cycle
    drive(1, 2, 32'hAAAA_5555, 32'h0F0F_0F0F, 1);
    drive(0, 0, '0, '0, 1);
    drive(0, 0, '0, '0, 1, 1);
    sb.delete();
    drive(0, 0, '0, '0, 1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", data_result, 32'h0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (12) begin
      drive(0, 0, '0, '0, 1);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end

    // same operation at three slice widths
    drive(1, 0, 32'hF0F0_FFFF, 32'h0FF0_00FF, 0);
    acc = cyc + 1;
    l32 = -1; l8 = -1; l4 = -1;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, '0, '0, 0);
      if (out_valid_32 && l32 < 0) l32 = cyc - acc;
      if (out_valid && l8 < 0)     l8  = cyc - acc;
      if (out_valid_4 && l4 < 0)   l4  = cyc - acc;
    end
    exp35 = model(2'b00, 32'hF0F0_FFFF, 32'h0FF0_00FF);
    chk("lat_slice32", 32'(l32), 32'd1);
    chk("lat_slice8", 32'(l8), 32'd4);
    chk("lat_slice4", 32'(l4), 32'd8);
    chk("res_slice32", data_result_32, exp35);
    chk("res_slice4", data_result_4, exp35);
    chk("zero_slice4", 32'(result_zero_4), 32'd0);
    drive(0, 0, '0, '0, 1);
    drive(0, 0, '0, '0, 1);

    repeat (150) begin
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      drive($urandom_range(0, 1), $urandom_range(0, 3), x, y, $urandom_range(0, 1));
    end
    for (int i = 0; i < 30 && sb.size() > 0; i++) drive(0, 0, '0, '0, 1);
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bw_logic_unit.md
BW_LOGIC_UNIT -- requirements
Module: bw_logic_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter SLICE, default 8, meaning bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE.
REQ-003 The block SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  operand request valid.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-007 The block SHALL have port op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 The block SHALL have port data_operandA  input  WIDTH  first operand.
REQ-009 The block SHALL have port data_operandB  input  WIDTH  second operand.
REQ-010 The block SHALL have port out_valid  output  1  result available.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 The block SHALL have port data_result  output  WIDTH  registered result.
REQ-013 The block SHALL have port result_zero  output  1  high when data_result == 0; meaningful only while out_valid = 1.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, BUSY, DONE.
REQ-015 in_ready SHALL be 1 in IDLE, 1 in DONE only when out_ready = 1, and 0 otherwise.
REQ-016 A request SHALL be accepted on a rising edge where in_valid & in_ready = 1; op, data_operandA and data_operandB SHALL be latched internally at that edge.
REQ-017 Inputs SHALL be ignored on any edge where no request is accepted; changes to inputs after acceptance SHALL NOT affect the result.
REQ-018 On acceptance the FSM SHALL enter BUSY, clear a slice counter to 0, and clear the result register to 0.
REQ-019 In BUSY, each cycle SHALL compute slice k (bits k*SLICE+SLICE-1 .. k*SLICE, LSB slice first) with the latched op, write it into the result register, and increment k.
REQ-020 After slice WIDTH/SLICE-1 is written, the FSM SHALL enter DONE; out_valid SHALL be asserted exactly WIDTH/SLICE edges after the accepting edge.
REQ-021 For SLICE = WIDTH the block SHALL spend exactly one cycle in BUSY.
REQ-022 In DONE, out_valid = 1, and data_result and result_zero SHALL remain stable until an edge with out_ready = 1.
REQ-023 DONE with out_ready = 1 and in_valid = 0 SHALL transition to IDLE with out_valid = 0 next cycle.
REQ-024 DONE with out_ready = 1 and in_valid = 1 SHALL retire the result and accept the new request on the same edge, entering BUSY directly.
REQ-025 out_valid SHALL be 0 in IDLE and BUSY; out_ready SHALL be ignored outside DONE.
REQ-026 data_result SHALL hold the last completed result in IDLE, and partial values in BUSY, which SHALL NOT be consumed.
REQ-027 The slice counter SHALL be wide enough for WIDTH/SLICE and SHALL NOT wrap while in BUSY.

Reset
REQ-028 reset = 1 at a rising edge SHALL force IDLE, counter 0, data_result 0, out_valid 0, and in_ready 1 on the following cycle.
REQ-029 reset SHALL take priority over any handshake on the same edge, and a reset in BUSY or DONE SHALL discard the operation with no result produced.

Verification
REQ-030 WIDTH=32, SLICE=8: op=00, A=0xF0F0_FFFF, B=0x0FF0_00FF -> out_valid 4 edges after accept, data_result=0x00F0_00FF, result_zero=0.
REQ-031 op=10, A=B=0xDEAD_BEEF -> data_result=0x0000_0000, result_zero=1; op=11, A=B=0 -> data_result=0xFFFF_FFFF.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in DONE while changing inputs -> result stable, in_ready=0, no new accept.
REQ-033 Back-to-back: in DONE, out_ready=1 and in_valid=1 with op=01, A=0x1, B=0x2 -> next result 0x3 four edges later, with no IDLE cycle.
REQ-034 Assert reset in the second BUSY cycle -> next cycle IDLE, out_valid=0, data_result=0, and no result ever presented for the aborted request.
REQ-035 Repeat REQ-030 with SLICE=32 (1-cycle latency) and SLICE=4 (8-cycle latency) -> identical data_result.
